cbus_sram_slave: RTL

CBUS_SRAM_SLAVE -- requirements
Module: cbus_sram_slave

---
 rtl/common_pkg.sv | 61 ++++++
 rtl/cbus_burst_addr.sv | 44 ++++
 rtl/cbus_sram_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// common -- shared CBUS types used by the SRAM slave and its address helper.
//
// Contents:
//   msize_t          transfer size code (carried on the bus, not used by the SRAM)
//   mlen_t           burst length, encoded as beats-1 (0..15)
//   cbus_burst_t     burst type: FIXED, INCR, WRAP
//   cbus_req_t       master request: valid, is_write, size, addr, strobe, data, len, burst
//   cbus_resp_t      slave response: ready, last, data
//   cbus_sram_state_t  SRAM slave FSM states
//   wrap_len_ok()    true when len+1 is a power of two (a usable WRAP window)
package common;

  localparam int CBUS_AW = 32;
  localparam int CBUS_DW = 64;
  localparam int CBUS_SW = CBUS_DW / 8;

  typedef enum logic [1:0] {
    MSIZE_1B = 2'd0,
    MSIZE_2B = 2'd1,
    MSIZE_4B = 2'd2,
    MSIZE_8B = 2'd3
  } msize_t;

  typedef logic [3:0] mlen_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } cbus_burst_t;

  typedef struct packed {
    logic               valid;
    logic               is_write;
    msize_t             size;
    logic [CBUS_AW-1:0] addr;
    logic [CBUS_SW-1:0] strobe;
    logic [CBUS_DW-1:0] data;
    mlen_t              len;
    cbus_burst_t        burst;
  } cbus_req_t;

  typedef struct packed {
    logic               ready;
    logic               last;
    logic [CBUS_DW-1:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } cbus_sram_state_t;

  function automatic logic wrap_len_ok(input mlen_t len);
    logic [4:0] n;
    n = {1'b0, len} + 5'd1;
    return (n & {1'b0, len}) == 5'd0;
  endfunction

endpackage

// File: rtl/cbus_burst_addr.sv
// cbus_burst_addr -- next word index for a CBUS burst (purely combinational).
//
// Ports:
//   index       current word index
//   len         latched burst length (beats-1)
//   burst       latched burst type
//   next_index  index of the following beat
//
// FIXED repeats the index, INCR steps by one modulo the memory size, WRAP steps
// within a (len+1)-word window aligned to its own size. A WRAP whose length is
// not a power of two has no aligned window and is treated as INCR.
import common::*;

module cbus_burst_addr #(
  parameter int IW = 12
) (
  input  logic [IW-1:0] index,
  input  mlen_t         len,
  input  cbus_burst_t   burst,
  output logic [IW-1:0] next_index
);

  logic [IW-1:0] incr;
  logic [IW-1:0] mask;

  always_comb begin
    incr       = index + IW'(1);
    mask       = IW'(len);
    next_index = incr;
    case (burst)
      BURST_FIXED: next_index = index;
      BURST_INCR:  next_index = incr;
      BURST_WRAP: begin
        // window base keeps the high bits; only the low len bits roll over
        if (wrap_len_ok(len))
          next_index = (index & ~mask) | (incr & mask);
        else
          next_index = incr;
      end
      default:     next_index = incr;
    endcase
  end

endmodule

// File: rtl/cbus_sram_slave.sv
// cbus_sram_slave -- 64-bit-word SRAM behind a CBUS slave port with bursts.
//
// Parameters:
//   DEPTH    memory size in 64-bit words (power of two, at least 16)
//   LATENCY  wait cycles before the first beat (delay build only)
//
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous, active-high
//   creq   request bus (valid, is_write, size, addr, strobe, data, len, burst)
//   cresp  response bus (ready, last, data), registered
//
// Build option: define CBUS_SRAM_DELAY_EN to insert a WAIT state of LATENCY
// cycles between acceptance and the first beat. Without it the first beat is
// presented the cycle after acceptance and LATENCY has no effect.
//
// state | meaning
// IDLE  | waiting for creq.valid; cresp all zero
// WAIT  | counting LATENCY cycles before the first beat (delay build only)
// BURST | one beat per cycle, ready=1; leaves on the beat with last=1
import common::*;

module cbus_sram_slave #(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int IW = $clog2(DEPTH);

  logic [CBUS_DW-1:0] mem [DEPTH];

  cbus_sram_state_t state_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    next_idx;
  logic [IW-1:0]    req_idx;
  mlen_t            len_q;
  mlen_t            beat_q;
  cbus_burst_t      burst_q;
  logic             is_write_q;
  cbus_resp_t       resp_q;

`ifdef CBUS_SRAM_DELAY_EN
  localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'((LATENCY > 0) ? LATENCY - 1 : 0);
  logic [WCW-1:0] wait_cnt;
`else
  localparam int unused_latency = LATENCY;
`endif

  // size and the byte offset do not affect a word-wide SRAM
  logic unused_req;
  assign unused_req = ^{creq.size, creq.addr};

  assign req_idx = creq.addr[3 +: IW];
  assign cresp   = resp_q;

  cbus_burst_addr #(.IW(IW)) u_burst_addr (
    .index      (idx_q),
    .len        (len_q),
    .burst      (burst_q),
    .next_index (next_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      burst_q    <= BURST_INCR;
      is_write_q <= 1'b0;
      resp_q     <= '0;
`ifdef CBUS_SRAM_DELAY_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          resp_q <= '0;
          if (creq.valid) begin
            idx_q      <= req_idx;
            len_q      <= creq.len;
            burst_q    <= creq.burst;
            is_write_q <= creq.is_write;
            beat_q     <= '0;
`ifdef CBUS_SRAM_DELAY_EN
            if (LATENCY > 0) begin
              state_q  <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state_q     <= BURST;
              resp_q.ready <= 1'b1;
              resp_q.last  <= (creq.len == '0);
              resp_q.data  <= creq.is_write ? '0 : mem[req_idx];
            end
`else
            state_q      <= BURST;
            resp_q.ready <= 1'b1;
            resp_q.last  <= (creq.len == '0);
            resp_q.data  <= creq.is_write ? '0 : mem[req_idx];
`endif
          end
        end

`ifdef CBUS_SRAM_DELAY_EN
        WAIT: begin
          if (wait_cnt == '0) begin
            state_q      <= BURST;
            resp_q.ready <= 1'b1;
            resp_q.last  <= (len_q == '0);
            resp_q.data  <= is_write_q ? '0 : mem[idx_q];
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
`endif

        BURST: begin
          if (resp_q.last) begin
            state_q <= IDLE;
            resp_q  <= '0;
            beat_q  <= '0;
          end else begin
            // outputs are registered, so the next beat's word is fetched now
            beat_q       <= beat_q + 1'b1;
            idx_q        <= next_idx;
            resp_q.ready <= 1'b1;
            resp_q.last  <= ((beat_q + 1'b1) == len_q);
            resp_q.data  <= is_write_q ? '0 : mem[next_idx];
          end
        end

        default: begin
          state_q <= IDLE;
          resp_q  <= '0;
        end
      endcase
    end
  end

  // No reset on the array; a reset forces IDLE asynchronously, which blocks
  // any write at the following edge.
  always_ff @(posedge clk) begin
    if (state_q == BURST && is_write_q) begin
      for (int b = 0; b < CBUS_SW; b++) begin
        if (creq.strobe[b])
          mem[idx_q][8*b +: 8] <= creq.data[8*b +: 8];
      end
    end
  end

endmodule
